// File: rtl/exe_ctrl.sv
// Execute-stage sequencer: single-cycle writeback, multi-cycle MUL/MULH, LW/SW handshake, branch flush.
// Optional EXE_MEM_TIMEOUT_EN adds a MEM_TIMEOUT-cycle abort on a missing mem_ack (pulses mem_err).
module exe_ctrl #(
   parameter int unsigned MUL_LAT = 3
`ifdef EXE_MEM_TIMEOUT_EN
   , parameter int unsigned MEM_TIMEOUT = 64
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_optype,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_store_data,
   input  logic [31:0] alu_res,
   input  logic        alu_write_reg,
   input  logic        alu_load_en,
   input  logic        alu_store_en,
   input  logic        alu_jmp_en,
   input  logic [31:0] alu_jmp_addr,
   output logic        stall,
   output logic        flush,
   output logic        pc_load,
   output logic [31:0] pc_target,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_err
);

   localparam int unsigned CW = $clog2(MUL_LAT + 1);
   // Decoder encodings of `I_MUL / `I_MULH
   localparam logic [4:0] OPT_MUL  = 5'd18;
   localparam logic [4:0] OPT_MULH = 5'd19;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_MEM, S_FLUSH} state_t;

   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [4:0]    r_rd, w_rd;
   logic          r_in_ready, w_in_ready;
   logic          r_stall, w_stall;
   logic          r_flush, w_flush;
   logic          r_pc_load, w_pc_load;
   logic [31:0]   r_pc_target, w_pc_target;
   logic          r_mem_req, w_mem_req;
   logic          r_mem_we, w_mem_we;
   logic [31:0]   r_mem_addr, w_mem_addr;
   logic [31:0]   r_mem_wdata, w_mem_wdata;
   logic          r_wb_en, w_wb_en;
   logic [4:0]    r_wb_rd, w_wb_rd;
   logic [31:0]   r_wb_data, w_wb_data;
   logic          w_accept;
   logic          w_is_mul;
`ifdef EXE_MEM_TIMEOUT_EN
   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
   logic [TW-1:0] r_wait, w_wait;
   logic          r_mem_err, w_mem_err;
`endif

   assign w_accept = in_valid & r_in_ready;
   assign w_is_mul = (in_optype == OPT_MUL) || (in_optype == OPT_MULH);

   // Next-state and next-output logic
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_rd        = r_rd;
      w_in_ready  = r_in_ready;
      w_stall     = r_stall;
      w_flush     = 1'b0;
      w_pc_load   = 1'b0;
      w_pc_target = r_pc_target;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_wb_en     = 1'b0;
      w_wb_rd     = r_wb_rd;
      w_wb_data   = r_wb_data;
`ifdef EXE_MEM_TIMEOUT_EN
      w_wait      = r_wait;
      w_mem_err   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (alu_jmp_en) begin
                  w_state     = S_FLUSH;
                  w_flush     = 1'b1;
                  w_pc_load   = 1'b1;
                  w_pc_target = alu_jmp_addr;
                  w_in_ready  = 1'b0;
               end else if (w_is_mul) begin
                  w_state    = S_MUL;
                  w_cnt      = CW'(MUL_LAT - 1);
                  w_rd       = in_rd;
                  w_stall    = 1'b1;
                  w_in_ready = 1'b0;
               end else if (alu_load_en || alu_store_en) begin
                  w_state     = S_MEM;
                  w_rd        = in_rd;
                  w_mem_req   = 1'b1;
                  w_mem_we    = alu_store_en;
                  w_mem_addr  = alu_res;
                  w_mem_wdata = in_store_data;
                  w_stall     = 1'b1;
                  w_in_ready  = 1'b0;
`ifdef EXE_MEM_TIMEOUT_EN
                  w_wait      = '0;
`endif
               end else if (alu_write_reg && (in_rd != 5'd0)) begin
                  w_wb_en   = 1'b1;
                  w_wb_rd   = in_rd;
                  w_wb_data = alu_res;
               end
            end
         end
         S_MUL: begin
            if (r_cnt == '0) begin
               w_state    = S_IDLE;
               w_stall    = 1'b0;
               w_in_ready = 1'b1;
               if (r_rd != 5'd0) begin
                  w_wb_en   = 1'b1;
                  w_wb_rd   = r_rd;
                  w_wb_data = alu_res;
               end
            end else begin
               w_cnt = r_cnt - CW'(1);
            end
         end
         S_MEM: begin
            // Ack wins over a simultaneous timeout expiry
            if (mem_ack) begin
               w_state    = S_IDLE;
               w_mem_req  = 1'b0;
               w_stall    = 1'b0;
               w_in_ready = 1'b1;
               if (!r_mem_we && (r_rd != 5'd0)) begin
                  w_wb_en   = 1'b1;
                  w_wb_rd   = r_rd;
                  w_wb_data = mem_rdata;
               end
            end
`ifdef EXE_MEM_TIMEOUT_EN
            else if (r_wait == TW'(MEM_TIMEOUT - 1)) begin
               w_state    = S_IDLE;
               w_mem_req  = 1'b0;
               w_stall    = 1'b0;
               w_in_ready = 1'b1;
               w_mem_err  = 1'b1;
            end else begin
               w_wait = r_wait + TW'(1);
            end
`endif
         end
         S_FLUSH: begin
            w_state    = S_IDLE;
            w_in_ready = 1'b1;
         end
         default: begin
            w_state    = S_IDLE;
            w_stall    = 1'b0;
            w_mem_req  = 1'b0;
            w_in_ready = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_rd        <= '0;
         r_in_ready  <= 1'b1;
         r_stall     <= 1'b0;
         r_flush     <= 1'b0;
         r_pc_load   <= 1'b0;
         r_pc_target <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_wb_en     <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
`ifdef EXE_MEM_TIMEOUT_EN
         r_wait      <= '0;
         r_mem_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_rd        <= w_rd;
         r_in_ready  <= w_in_ready;
         r_stall     <= w_stall;
         r_flush     <= w_flush;
         r_pc_load   <= w_pc_load;
         r_pc_target <= w_pc_target;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_wb_en     <= w_wb_en;
         r_wb_rd     <= w_wb_rd;
         r_wb_data   <= w_wb_data;
`ifdef EXE_MEM_TIMEOUT_EN
         r_wait      <= w_wait;
         r_mem_err   <= w_mem_err;
`endif
      end
   end

   assign in_ready  = r_in_ready;
   assign stall     = r_stall;
   assign flush     = r_flush;
   assign pc_load   = r_pc_load;
   assign pc_target = r_pc_target;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign wb_en     = r_wb_en;
   assign wb_rd     = r_wb_rd;
   assign wb_data   = r_wb_data;
`ifdef EXE_MEM_TIMEOUT_EN
   assign mem_err   = r_mem_err;
`else
   assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_exe_ctrl.sv
// Directed bench for exe_ctrl: writeback expectations are queued at issue and popped on wb_en.
module tb_exe_ctrl;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_BEQ = 5'd8;
   localparam logic [4:0] OP_LW  = 5'd12;
   localparam logic [4:0] OP_SW  = 5'd13;
   localparam logic [4:0] OP_MUL = 5'd18;
   localparam logic [4:0] OP_BAD = 5'd31;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready;
   logic [4:0]  in_optype, in_rd;
   logic [31:0] in_store_data, alu_res, alu_jmp_addr;
   logic        alu_write_reg, alu_load_en, alu_store_en, alu_jmp_en;
   logic        stall, flush, pc_load, mem_req, mem_we, mem_ack, wb_en, mem_err;
   logic [31:0] pc_target, mem_addr, mem_wdata, mem_rdata, wb_data;
   logic [4:0]  wb_rd;

   int n_checks = 0;
   int n_errors = 0;
   wb_t exp_q[$];

   always #5 clk = ~clk;

   exe_ctrl #(
      .MUL_LAT(3)
`ifdef EXE_MEM_TIMEOUT_EN
      , .MEM_TIMEOUT(4)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_optype(in_optype), .in_rd(in_rd),
      .in_store_data(in_store_data), .alu_res(alu_res), .alu_write_reg(alu_write_reg),
      .alu_load_en(alu_load_en), .alu_store_en(alu_store_en), .alu_jmp_en(alu_jmp_en),
      .alu_jmp_addr(alu_jmp_addr), .stall(stall), .flush(flush), .pc_load(pc_load),
      .pc_target(pc_target), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en),
      .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_optype = OP_ADD; in_rd = 5'd0; in_store_data = '0;
      alu_res = '0; alu_write_reg = 1'b0; alu_load_en = 1'b0; alu_store_en = 1'b0;
      alu_jmp_en = 1'b0; alu_jmp_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic alu_op(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] res);
      idle_in();
      in_valid = 1'b1; in_optype = op; in_rd = rd; alu_res = res; alu_write_reg = 1'b1;
   endtask

   // Scoreboard consumer: every wb pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && wb_en) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", wb_data, e.data);
         end
      end
   end

   initial begin
      idle_in();
      tick(); tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flush_pcl", 32'({flush, pc_load}), 32'd0);
      chk("rst_pc_target", pc_target, 32'd0);
      chk("rst_mem", {29'd0, mem_req, mem_we, mem_err}, 32'd0);
      chk("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
      chk("rst_wb", {26'd0, wb_en, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // ADD rd=5 -> wb next cycle
      alu_op(OP_ADD, 5'd5, 32'h12);
      exp_q.push_back('{rd: 5'd5, data: 32'h12});
      tick();
      chk("add_wb_en", 32'(wb_en), 32'd1);
      chk("add_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back ADDI rd=1, rd=2
      alu_op(OP_ADD, 5'd1, 32'h21);
      exp_q.push_back('{rd: 5'd1, data: 32'h21});
      tick();
      chk("b2b1_stall", 32'(stall), 32'd0);
      alu_op(OP_ADD, 5'd2, 32'h22);
      exp_q.push_back('{rd: 5'd2, data: 32'h22});
      tick();
      chk("b2b2_wb_en", 32'(wb_en), 32'd1);
      chk("b2b2_in_ready", 32'(in_ready), 32'd1);

      // rd=0 never written
      alu_op(OP_ADD, 5'd0, 32'h55);
      tick();
      chk("x0_wb_en", 32'(wb_en), 32'd0);
      chk("x0_wb_rd_hold", 32'(wb_rd), 32'd2);

      // Unknown optype, no flags -> NOP
      idle_in();
      in_valid = 1'b1; in_optype = OP_BAD; in_rd = 5'd9; alu_res = 32'h99;
      tick();
      chk("nop_wb_en", 32'(wb_en), 32'd0);
      chk("nop_stall", 32'(stall), 32'd0);

      // MUL rd=3, MUL_LAT=3: stall 3 cycles, wb at t+4
      alu_op(OP_MUL, 5'd3, 32'h20);
      exp_q.push_back('{rd: 5'd3, data: 32'h20});
      tick();
      chk("mul_stall1", 32'(stall), 32'd1);
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("mul_stall2", 32'(stall), 32'd1);
      tick();
      chk("mul_stall3", 32'(stall), 32'd1);
      chk("mul_early_wb", 32'(wb_en), 32'd0);
      in_valid = 1'b0;
      tick();
      chk("mul_stall_drop", 32'(stall), 32'd0);
      chk("mul_wb_en", 32'(wb_en), 32'd1);
      chk("mul_ready_back", 32'(in_ready), 32'd1);
      idle_in();

      // LW rd=7 @0x100, ack on 5th request cycle
      idle_in();
      in_valid = 1'b1; in_optype = OP_LW; in_rd = 5'd7; alu_res = 32'h100; alu_load_en = 1'b1;
      exp_q.push_back('{rd: 5'd7, data: 32'hDEAD});
      tick();
      idle_in();
      alu_res = 32'hBAD0;
      chk("lw_stall", 32'(stall), 32'd1);
      chk("lw_we", 32'(mem_we), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         chk("lw_req", 32'(mem_req), 32'd1);
         chk("lw_addr", mem_addr, 32'h100);
         if (i == 5) begin
            mem_ack = 1'b1; mem_rdata = 32'hDEAD;
         end
         tick();
      end
      mem_ack = 1'b0; mem_rdata = '0;
      chk("lw_req_drop", 32'(mem_req), 32'd0);
      chk("lw_stall_drop", 32'(stall), 32'd0);
      chk("lw_wb_en", 32'(wb_en), 32'd1);

      // Stray ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'hFFFF;
      tick();
      mem_ack = 1'b0;
      chk("stray_ack_wb", 32'(wb_en), 32'd0);
      chk("stray_ack_req", 32'(mem_req), 32'd0);

      // SW @0x200 data 0xCAFE, immediate ack, no wb
      idle_in();
      in_valid = 1'b1; in_optype = OP_SW; in_rd = 5'd9; alu_res = 32'h200;
      in_store_data = 32'hCAFE; alu_store_en = 1'b1;
      tick();
      idle_in();
      chk("sw_req", 32'(mem_req), 32'd1);
      chk("sw_we", 32'(mem_we), 32'd1);
      chk("sw_addr", mem_addr, 32'h200);
      chk("sw_wdata", mem_wdata, 32'hCAFE);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("sw_req_drop", 32'(mem_req), 32'd0);
      chk("sw_no_wb", 32'(wb_en), 32'd0);

      // Taken BEQ -> flush/pc_load, next op discarded
      idle_in();
      in_valid = 1'b1; in_optype = OP_BEQ; alu_jmp_en = 1'b1; alu_jmp_addr = 32'h40;
      tick();
      chk("beq_flush", 32'({flush, pc_load}), 32'd3);
      chk("beq_target", pc_target, 32'h40);
      chk("beq_in_ready", 32'(in_ready), 32'd0);
      alu_op(OP_ADD, 5'd4, 32'h44);
      tick();
      idle_in();
      chk("beq_flush_drop", 32'({flush, pc_load}), 32'd0);
      chk("beq_no_wb", 32'(wb_en), 32'd0);
      chk("beq_ready_back", 32'(in_ready), 32'd1);
      tick();
      chk("beq_killed_wb", 32'(wb_en), 32'd0);

`ifdef EXE_MEM_TIMEOUT_EN
      // SW with no ack, MEM_TIMEOUT=4
      idle_in();
      in_valid = 1'b1; in_optype = OP_SW; alu_res = 32'h300; alu_store_en = 1'b1;
      tick();
      idle_in();
      for (int i = 1; i <= 4; i++) begin
         chk("to_req", 32'(mem_req), 32'd1);
         chk("to_err_early", 32'(mem_err), 32'd0);
         tick();
      end
      chk("to_req_drop", 32'(mem_req), 32'd0);
      chk("to_err", 32'(mem_err), 32'd1);
      chk("to_ready", 32'(in_ready), 32'd1);
      tick();
      chk("to_err_pulse", 32'(mem_err), 32'd0);
`else
      chk("mem_err_tied", 32'(mem_err), 32'd0);
`endif

      // Reset mid-MUL abandons the op
      alu_op(OP_MUL, 5'd6, 32'h66);
      tick();
      in_valid = 1'b0;
      chk("rmul_stall", 32'(stall), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rmul_stall0", 32'(stall), 32'd0);
      chk("rmul_ready", 32'(in_ready), 32'd1);
      chk("rmul_wb", {26'd0, wb_en, wb_rd}, 32'd0);
      chk("rmul_wb_data", wb_data, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("rmul_no_wb", 32'(wb_en), 32'd0);
      chk("rmul_idle_stall", 32'(stall), 32'd0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
